// File: rtl/dekatron_counter_chain_if.sv
// rtl/dekatron_counter_chain_if.sv - step/load handshake and tube guide bundle for the dekatron chain
interface dekatron_counter_chain_if #(
   parameter int DIGITS = 3
);
   logic                   Request;
   logic                   Dec;
   logic                   Set;
   logic [DIGITS*10-1:0]   In;
   logic [DIGITS*10-1:0]   Out;
   logic                   Ready;
   logic                   Zero;
   logic                   Overflow;
   logic [DIGITS-1:0]      PulseRight_n;
   logic [DIGITS-1:0]      PulseLeft_n;

   modport master (
      output Request, Dec, Set, In,
      input  Out, Ready, Zero, Overflow, PulseRight_n, PulseLeft_n
   );

   modport slave (
      input  Request, Dec, Set, In,
      output Out, Ready, Zero, Overflow, PulseRight_n, PulseLeft_n
   );
endinterface

// File: rtl/dekatron_counter_chain.sv
// rtl/dekatron_counter_chain.sv - chained one-hot decimal dekatron counter with two-phase guide sequencer
module dekatron_counter_chain #(
   parameter int DIGITS       = 3,
   parameter int PULSE_CYCLES = 1
) (
   input  logic                   Clk,
   input  logic                   Rst_n,
   dekatron_counter_chain_if.slave bus
);
   localparam int              SW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [SW-1:0]   MSB_SEL  = SW'(DIGITS - 1);
   localparam logic [3:0]      LAST_CNT = 4'(PULSE_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, PHASE_A, PHASE_B} state_t;

   state_t                  state_q, state_d;
   logic [DIGITS-1:0][9:0]  digits_q, digits_d;
   logic [SW-1:0]           sel_q, sel_d;
   logic                    dir_q, dir_d;
   logic [3:0]              cnt_q, cnt_d;
   logic                    ready_q, ready_d;
   logic                    overflow_q, overflow_d;
   logic [DIGITS-1:0]       pr_n_q, pr_n_d;
   logic [DIGITS-1:0]       pl_n_q, pl_n_d;

   logic [9:0]              cur_digit;
   logic [9:0]              rot_digit;
   logic                    wrapped;
   logic [DIGITS-1:0]       digit_zero;

   // Rotate the selected digit one cathode in the latched direction and flag a wrap
   always_comb begin
      cur_digit = digits_q[sel_q];
      if (dir_q) begin
         rot_digit = {cur_digit[0], cur_digit[9:1]};
         wrapped   = cur_digit[0];
      end else begin
         rot_digit = {cur_digit[8:0], cur_digit[9]};
         wrapped   = cur_digit[9];
      end
   end

   // Next-state: load, step acceptance, phase timing, commit and carry/borrow ripple
   always_comb begin
      state_d    = state_q;
      digits_d   = digits_q;
      sel_d      = sel_q;
      dir_d      = dir_q;
      cnt_d      = cnt_q;
      overflow_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.Set) begin
               // A malformed digit falls back to cathode 0 rather than loading garbage
               for (int d = 0; d < DIGITS; d++) begin
                  if ($onehot(bus.In[d*10 +: 10])) digits_d[d] = bus.In[d*10 +: 10];
                  else                             digits_d[d] = 10'b0000000001;
               end
            end else if (bus.Request) begin
               dir_d   = bus.Dec;
               sel_d   = '0;
               cnt_d   = '0;
               state_d = PHASE_A;
            end
         end
         PHASE_A: begin
            if (cnt_q == LAST_CNT) begin
               cnt_d   = '0;
               state_d = PHASE_B;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         PHASE_B: begin
            if (cnt_q == LAST_CNT) begin
               digits_d[sel_q] = rot_digit;
               cnt_d           = '0;
               if (wrapped && (sel_q != MSB_SEL)) begin
                  sel_d   = sel_q + SW'(1);
                  state_d = PHASE_A;
               end else begin
                  overflow_d = wrapped;
                  state_d    = IDLE;
               end
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Guide pulses and Ready follow the upcoming state so they register with it
   always_comb begin
      pr_n_d  = '1;
      pl_n_d  = '1;
      ready_d = (state_d == IDLE);
      if (state_d == PHASE_A) begin
         if (dir_d) pl_n_d[sel_d] = 1'b0;
         else       pr_n_d[sel_d] = 1'b0;
      end else if (state_d == PHASE_B) begin
         if (dir_d) pr_n_d[sel_d] = 1'b0;
         else       pl_n_d[sel_d] = 1'b0;
      end
   end

   // State and output registers; reset parks every tube on cathode 0
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q    <= IDLE;
         for (int d = 0; d < DIGITS; d++) digits_q[d] <= 10'b0000000001;
         sel_q      <= '0;
         dir_q      <= 1'b0;
         cnt_q      <= '0;
         ready_q    <= 1'b1;
         overflow_q <= 1'b0;
         pr_n_q     <= '1;
         pl_n_q     <= '1;
      end else begin
         state_q    <= state_d;
         digits_q   <= digits_d;
         sel_q      <= sel_d;
         dir_q      <= dir_d;
         cnt_q      <= cnt_d;
         ready_q    <= ready_d;
         overflow_q <= overflow_d;
         pr_n_q     <= pr_n_d;
         pl_n_q     <= pl_n_d;
      end
   end

   // Zero decodes cathode 0 of every digit
   always_comb begin
      for (int d = 0; d < DIGITS; d++) digit_zero[d] = digits_q[d][0];
   end

   assign bus.Out          = digits_q;
   assign bus.Ready        = ready_q;
   assign bus.Zero         = &digit_zero;
   assign bus.Overflow     = overflow_q;
   assign bus.PulseRight_n = pr_n_q;
   assign bus.PulseLeft_n  = pl_n_q;
endmodule

// File: tb/tb_dekatron_counter_chain.sv
// tb/tb_dekatron_counter_chain.sv - directed self-checking bench for dekatron_counter_chain
module tb_dekatron_counter_chain;
   logic        Clk;
   logic        rst_n;
   logic        sel;
   logic        req;
   logic        dec;
   logic        set;
   logic [29:0] in_v;

   int n_checks = 0;
   int n_fail   = 0;

   dekatron_counter_chain_if #(.DIGITS(3)) b1 ();
   dekatron_counter_chain_if #(.DIGITS(3)) b3 ();

   dekatron_counter_chain #(.DIGITS(3), .PULSE_CYCLES(1)) dut1 (.Clk(Clk), .Rst_n(rst_n), .bus(b1.slave));
   dekatron_counter_chain #(.DIGITS(3), .PULSE_CYCLES(3)) dut3 (.Clk(Clk), .Rst_n(rst_n), .bus(b3.slave));

   assign b1.Request = sel ? 1'b0 : req;
   assign b1.Set     = sel ? 1'b0 : set;
   assign b1.Dec     = dec;
   assign b1.In      = in_v;
   assign b3.Request = sel ? req : 1'b0;
   assign b3.Set     = sel ? set : 1'b0;
   assign b3.Dec     = dec;
   assign b3.In      = in_v;

   logic [29:0] o_out;
   logic        o_ready, o_zero, o_ovf;
   logic [2:0]  o_pr, o_pl;
   assign o_out   = sel ? b3.Out          : b1.Out;
   assign o_ready = sel ? b3.Ready        : b1.Ready;
   assign o_zero  = sel ? b3.Zero         : b1.Zero;
   assign o_ovf   = sel ? b3.Overflow     : b1.Overflow;
   assign o_pr    = sel ? b3.PulseRight_n : b1.PulseRight_n;
   assign o_pl    = sel ? b3.PulseLeft_n  : b1.PulseLeft_n;

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   function automatic logic [29:0] val(input int n);
      logic [29:0] r;
      int          v;
      r = '0;
      v = n;
      for (int d = 0; d < 3; d++) begin
         r[d*10 +: 10] = 10'b1 << (v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   // Issue one step and trace the guides: nibble 2*d is right guide of digit d, 2*d+1 is left
   task automatic do_step(input bit d, output int busy, output logic [63:0] seq, output int viol);
      logic [3:0] code;
      int         nlow;
      req  = 1'b1;
      dec  = d;
      tick();
      req  = 1'b0;
      busy = 0;
      seq  = '1;
      viol = 0;
      while (o_ready == 1'b0 && busy < 200) begin
         code = 4'hF;
         nlow = 0;
         for (int i = 0; i < 3; i++) begin
            if (!o_pr[i]) begin code = 4'(2*i);     nlow++; end
            if (!o_pl[i]) begin code = 4'(2*i + 1); nlow++; end
         end
         if (nlow != 1) viol++;
         seq = {seq[59:0], code};
         busy++;
         tick();
      end
   endtask

   int          busy, viol;
   logic [63:0] seq;

   initial begin
      rst_n = 1'b0; sel = 1'b0; req = 1'b0; dec = 1'b0; set = 1'b0; in_v = '0;
      tick();
      check("rst_out",   o_out,   val(0));
      check("rst_ready", o_ready, 1);
      check("rst_zero",  o_zero,  1);
      check("rst_ovf",   o_ovf,   0);
      check("rst_pulse", {o_pr, o_pl}, 6'h3F);
      rst_n = 1'b1;
      tick();

      // three increments from 000
      for (int s = 0; s < 3; s++) begin
         do_step(1'b0, busy, seq, viol);
         check("inc_busy", busy, 2);
         check("inc_seq",  seq,  64'hFFFF_FFFF_FFFF_FF01);
         check("inc_ovf",  o_ovf, 0);
      end
      check("inc_val",  o_out,  val(3));
      check("inc_zero", o_zero, 0);

      // 009 + 1 ripples into digit 1
      set = 1'b1; in_v = val(9); tick(); set = 1'b0;
      check("load9", o_out, val(9));
      do_step(1'b0, busy, seq, viol);
      check("c10_busy", busy, 4);
      check("c10_seq",  seq,  64'hFFFF_FFFF_FFFF_0123);
      check("c10_viol", viol, 0);
      check("c10_ovf",  o_ovf, 0);
      check("c10_val",  o_out, val(10));

      // 000 - 1 borrows through every digit and overflows
      set = 1'b1; in_v = val(0); tick(); set = 1'b0;
      check("load0_zero", o_zero, 1);
      do_step(1'b1, busy, seq, viol);
      check("b999_busy", busy, 6);
      check("b999_seq",  seq,  64'hFFFF_FFFF_FF10_3254);
      check("b999_viol", viol, 0);
      check("b999_ovf",  o_ovf, 1);
      check("b999_val",  o_out, val(999));
      check("b999_zero", o_zero, 0);
      tick();
      check("b999_ovf_end", o_ovf, 0);

      // invalid digit loads cathode 0; simultaneous Request is dropped
      in_v = '0;
      in_v[9:0]   = 10'b0001000000;
      in_v[19:10] = 10'b0000000011;
      in_v[29:20] = 10'b0000000001;
      set = 1'b1; req = 1'b1; tick(); set = 1'b0; req = 1'b0;
      check("set_val",   o_out,   val(6));
      check("set_ready", o_ready, 1);
      check("set_pulse", {o_pr, o_pl}, 6'h3F);
      tick();
      check("set_ready2", o_ready, 1);
      check("set_ovf",    o_ovf,   0);
      check("set_val2",   o_out,   val(6));

      // asynchronous reset during PHASE_B of digit 1 in a 099 ripple
      set = 1'b1; in_v = val(99); tick(); set = 1'b0;
      req = 1'b1; dec = 1'b0; tick(); req = 1'b0;
      tick(); tick(); tick();
      check("mid_phaseb", o_pl, 3'b101);
      rst_n = 1'b0;
      #1;
      check("mid_out",   o_out,   val(0));
      check("mid_ready", o_ready, 1);
      check("mid_pulse", {o_pr, o_pl}, 6'h3F);
      tick();
      rst_n = 1'b1;
      tick();
      check("mid_ovf",   o_ovf, 0);
      check("mid_out2",  o_out, val(0));

      // PULSE_CYCLES=3 instance: 099 + 1
      sel = 1'b1;
      set = 1'b1; in_v = val(99); tick(); set = 1'b0;
      do_step(1'b0, busy, seq, viol);
      check("p3_busy", busy, 18);
      check("p3_seq",  seq,  64'h0111_2223_3344_4555);
      check("p3_viol", viol, 0);
      check("p3_ovf",  o_ovf, 0);
      check("p3_val",  o_out, val(100));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/dekatron_counter_chain.md
Name: dekatron_counter_chain

Overview:
- Multi-digit decimal counter built from chained dekatron models. Each digit holds a one-hot 10-bit cathode position.
- A built-in two-phase guide-pulse sequencer steps the low digit up or down one count per request. Carry or borrow ripples digit by digit, with real pulse sequences for each digit.
- Generalised successor of the single pulse-sender and single-bulb pair. Feeds the data/address counters of the DekatronPC and drives external tube guide outputs per digit.

Parameters:
- DIGITS, 3, number of chained decimal digits (1..8); digit 0 is least significant.
- PULSE_CYCLES, 1, length in Clk cycles of each guide-pulse phase (1..15).

Ports:
- Clk  in  1  system clock, rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- Request  in  1  step request, sampled when Ready=1.
- Dec  in  1  direction for the sampled Request: 0 = +1, 1 = -1.
- Set  in  1  parallel load strobe, sampled when Ready=1.
- In  in  DIGITS*10  load value; digit d is at bits [10d+9:10d], one-hot.
- Out  out  DIGITS*10  current cathode positions, one-hot per digit.
- Ready  out  1  1 = idle, accepts Request/Set.
- Zero  out  1  1 when every digit is at position 0; combinational from Out.
- Overflow  out  1  one-cycle pulse when the most significant digit wraps (9->0 on inc, 0->9 on dec).
- PulseRight_n  out  DIGITS  per-digit right guide pulse, active low.
- PulseLeft_n  out  DIGITS  per-digit left guide pulse, active low.

Behaviour:
- Reset (async, Rst_n=0):
  - Every digit is 10'b0000000001; Ready=1, Zero=1, Overflow=0.
  - All PulseRight_n/PulseLeft_n=1; FSM=IDLE; latched direction=0.
  - Reset mid-operation aborts immediately; no partial carry survives.
- FSM states: IDLE, PHASE_A, PHASE_B.
- IDLE:
  - Set=1 at an edge loads In into Out at that edge. Ready stays 1; no pulses are generated.
  - A digit of In that is not exactly one-hot loads 10'b0000000001.
  - Set has priority over a simultaneous Request; that Request is dropped.
  - Request=1 (Set=0) at an edge latches Dec, selects digit 0, enters PHASE_A and drops Ready.
- PHASE_A, lasting PULSE_CYCLES cycles:
  - Inc drives the selected digit's PulseRight_n low; dec drives its PulseLeft_n low.
  - All other pulse bits stay high.
- PHASE_B, lasting PULSE_CYCLES cycles: the opposite guide of the selected digit is low.
- At the last PHASE_B edge:
  - The selected digit rotates: inc moves bit k to k+1 with 9->0; dec moves bit k to k-1 with 0->9.
  - All pulses return high.
  - If the digit wrapped and is not the MSB, select the next digit and enter PHASE_A at that edge (no idle gap).
  - If the MSB wrapped, assert Overflow for the following cycle and go to IDLE.
  - Otherwise go to IDLE. Ready=1 from that edge.
- Latency: Ready is low for 2*PULSE_CYCLES*k cycles, where k = number of digits stepped (1..DIGITS).
- Request/Set while Ready=0 are ignored; there is no queueing.
- The two guides of one digit are never low at the same time. At most one digit pulses at a time.
- Out changes only at load or commit edges. It is always one-hot per digit.
- Overflow is never asserted for a Set.

Test Plan:
- Reset then 3 inc Requests (DIGITS=3, PULSE_CYCLES=1) -> digit 0 = bit 3, value 003. Each step: PulseRight_n[0] low 1 cycle, then PulseLeft_n[0] low 1 cycle. Ready low 2 cycles per step; Zero=0.
- Set In = digit 0 = 10'b1000000000, others position 0 (value 009), then inc -> value 010. Ready low 4 cycles. Pulses on digit 0 then digit 1, never overlapping. Overflow=0.
- From reset (000), one dec Request -> value 999. Ready low 6 cycles. Overflow high exactly 1 cycle after Ready rises; Zero falls.
- Set with digit 0 = 10'b0001000000 and digit 1 = 10'b0000000011 (invalid) -> value 006. No pulses; Ready stays 1. Request on the same edge is dropped.
- PULSE_CYCLES=3, value 099 inc -> value 100. Each phase lasts 3 cycles; Ready low 18 cycles.
- Assert Rst_n=0 during PHASE_B of a carry ripple -> all Out = position 0, pulses high and Ready=1 immediately. No Overflow afterwards.
